// File: rtl/mult_div_ctrl_if.sv
// Request/response bus between the CPU control unit and the mult/div sequencer.
// master = control unit, slave = sequencer.
interface mult_div_ctrl_if;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  op_sel;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    modport master (
        output op_valid, op_sel, src_a, src_b,
        input  op_ready, hi, lo, busy, done, div_zero
    );

    modport slave (
        input  op_valid, op_sel, src_a, src_b,
        output op_ready, hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_ctrl.sv
// Sequencer launching the fixed-latency multiplier/divider and owning HI/LO.
// Optional abort input enabled by defining MULT_DIV_ABORT_EN.
module mult_div_ctrl #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic           clock,
    input  logic           reset_n,
`ifdef MULT_DIV_ABORT_EN
    input  logic           abort,
`endif
    mult_div_ctrl_if.slave bus,
    output logic           mu_start,
    output logic           du_start,
    output logic [31:0]    unit_a,
    output logic [31:0]    unit_b,
    input  logic [31:0]    mu_hi,
    input  logic [31:0]    mu_lo,
    input  logic [31:0]    du_quot,
    input  logic [31:0]    du_rem
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH_M,
        S_LAUNCH_D,
        S_WAIT,
        S_CAPTURE,
        S_RETIRE
    } state_t;

    typedef enum logic [1:0] {
        OP_MULT = 2'b00,
        OP_DIV  = 2'b01,
        OP_MTHI = 2'b10,
        OP_MTLO = 2'b11
    } op_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             mu_start_next;
    logic             du_start_next;
    logic             done_next;
    logic             accept;
    logic             capture;
    logic             kill;
    logic             is_div;
    logic             b_zero;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic             done_r;
    logic             div_zero_r;
    op_t              op;

    assign op     = op_t'(bus.op_sel);
    assign b_zero = (bus.src_b == '0);

`ifdef MULT_DIV_ABORT_EN
    assign kill = abort && (state != S_IDLE);
`else
    assign kill = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        mu_start_next = 1'b0;
        du_start_next = 1'b0;
        done_next     = 1'b0;
        accept        = 1'b0;
        capture       = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.op_valid) begin
                    accept = 1'b1;
                    case (op)
                        OP_MULT: begin
                            state_next    = S_LAUNCH_M;
                            mu_start_next = 1'b1;
                        end
                        OP_DIV: begin
                            if (b_zero) begin
                                state_next = S_RETIRE;
                            end else begin
                                state_next    = S_LAUNCH_D;
                                du_start_next = 1'b1;
                            end
                        end
                        default: state_next = S_RETIRE;
                    endcase
                end
            end
            S_LAUNCH_M: begin
                cnt_next   = CNT_W'(MULT_CYCLES - 1);
                state_next = S_WAIT;
            end
            S_LAUNCH_D: begin
                cnt_next   = CNT_W'(DIV_CYCLES - 1);
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_next = S_CAPTURE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            S_CAPTURE: begin
                capture    = 1'b1;
                done_next  = 1'b1;
                state_next = S_IDLE;
            end
            S_RETIRE: begin
                done_next  = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        // Abort overrides whatever the in-flight state would have committed.
        if (kill) begin
            state_next = S_IDLE;
            done_next  = 1'b0;
            capture    = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi_r       <= '0;
            lo_r       <= '0;
            unit_a     <= '0;
            unit_b     <= '0;
            mu_start   <= 1'b0;
            du_start   <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            is_div     <= 1'b0;
        end else begin
            mu_start <= mu_start_next;
            du_start <= du_start_next;
            done_r   <= done_next;
            if (accept) begin
                unit_a     <= bus.src_a;
                unit_b     <= bus.src_b;
                is_div     <= (op == OP_DIV);
                div_zero_r <= (op == OP_DIV) && b_zero;
                if (op == OP_MTHI) hi_r <= bus.src_a;
                if (op == OP_MTLO) lo_r <= bus.src_a;
            end else if (capture) begin
                if (is_div) begin
                    hi_r <= du_rem;
                    lo_r <= du_quot;
                end else begin
                    hi_r <= mu_hi;
                    lo_r <= mu_lo;
                end
            end
        end
    end

    assign bus.op_ready = (state == S_IDLE);
    assign bus.busy     = (state != S_IDLE);
    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;
    assign bus.done     = done_r;
    assign bus.div_zero = div_zero_r;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard bench for mult_div_ctrl: directed requests push expected
// responses; a negedge monitor pops them on done / start pulses.
module tb_mult_div_ctrl;

    localparam int MULT_CYCLES = 32;
    localparam int DIV_CYCLES  = 32;
    localparam int LAT         = MULT_CYCLES + 2;
    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        mu_start, du_start;
    logic [31:0] unit_a, unit_b;
    logic [31:0] mu_hi, mu_lo, du_quot, du_rem;
`ifdef MULT_DIV_ABORT_EN
    logic        abort = 1'b0;
`endif

    mult_div_ctrl_if bus ();

    mult_div_ctrl #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (6)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
`ifdef MULT_DIV_ABORT_EN
        .abort   (abort),
`endif
        .bus     (bus),
        .mu_start(mu_start),
        .du_start(du_start),
        .unit_a  (unit_a),
        .unit_b  (unit_b),
        .mu_hi   (mu_hi),
        .mu_lo   (mu_lo),
        .du_quot (du_quot),
        .du_rem  (du_rem)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Unit models: outputs are garbage until the unit's latency has elapsed.
    int mcnt = 0;
    int dcnt = 0;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mcnt <= 0;
            dcnt <= 0;
        end else begin
            if (mu_start) mcnt <= 1;
            else if (mcnt != 0 && mcnt < 1000) mcnt <= mcnt + 1;
            if (du_start) dcnt <= 1;
            else if (dcnt != 0 && dcnt < 1000) dcnt <= dcnt + 1;
        end
    end

    logic signed [63:0] prod;
    logic signed [31:0] quot_m, rem_m;
    assign prod   = $signed({{32{unit_a[31]}}, unit_a}) * $signed({{32{unit_b[31]}}, unit_b});
    assign quot_m = (unit_b == 0) ? 32'sd0 : $signed(unit_a) / $signed(unit_b);
    assign rem_m  = (unit_b == 0) ? 32'sd0 : $signed(unit_a) % $signed(unit_b);
    assign {mu_hi, mu_lo} = (mcnt >= MULT_CYCLES) ? prod : 64'hBAD0_BAD0_BAD0_BAD0;
    assign du_quot = (dcnt >= DIV_CYCLES) ? quot_m : 32'hBAD1_BAD1;
    assign du_rem  = (dcnt >= DIV_CYCLES) ? rem_m  : 32'hBAD2_BAD2;

    typedef struct {
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } resp_t;

    typedef struct {
        int         cyc;
        logic [1:0] starts;
    } start_t;

    resp_t  sb[$];
    start_t st_q[$];
    resp_t  r_exp;
    start_t s_exp;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(bus.done), 64'd0);
                end else begin
                    r_exp = sb.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(r_exp.cyc));
                    chk("hi", 64'(bus.hi), 64'(r_exp.hi));
                    chk("lo", 64'(bus.lo), 64'(r_exp.lo));
                    chk("div_zero", 64'(bus.div_zero), 64'(r_exp.dz));
                end
            end
            if (mu_start || du_start) begin
                if (st_q.size() == 0) begin
                    chk("unexpected_start", 64'({mu_start, du_start}), 64'd0);
                end else begin
                    s_exp = st_q.pop_front();
                    chk("start_cycle", 64'(cyc), 64'(s_exp.cyc));
                    chk("start_sel", 64'({mu_start, du_start}), 64'(s_exp.starts));
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic edz,
                         input int lat, output int acc);
        int n;
        @(negedge clock);
        bus.op_valid = 1'b1;
        bus.op_sel   = op;
        bus.src_a    = a;
        bus.src_b    = b;
        n = 0;
        while (!bus.op_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!bus.op_ready) begin
            chk("accept_timeout", 64'(bus.op_ready), 64'd1);
            bus.op_valid = 1'b0;
            acc = -1;
        end else begin
            @(posedge clock);
            #1;
            acc = cyc;
            sb.push_back('{acc + lat, eh, el, edz});
            if (op == OP_MULT) st_q.push_back('{acc, 2'b10});
            else if (op == OP_DIV && b != 0) st_q.push_back('{acc, 2'b01});
            chk("unit_a", 64'(unit_a), 64'(a));
            chk("unit_b", 64'(unit_b), 64'(b));
            bus.op_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int acc2;
        int n;
        bus.op_valid = 1'b0;
        bus.op_sel   = 2'b00;
        bus.src_a    = '0;
        bus.src_b    = '0;

        repeat (3) @(negedge clock);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_ready", 64'(bus.op_ready), 64'd1);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_div_zero", 64'(bus.div_zero), 64'd0);
        chk("rst_unit_a", 64'(unit_a), 64'd0);
        chk("rst_starts", 64'({mu_start, du_start}), 64'd0);
        #2 reset_n = 1'b1;

        issue(OP_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, LAT, acc);
        issue(OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, LAT, acc);
        issue(OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, LAT, acc);
        issue(OP_MTHI, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFF2, 1'b0, 1, acc);
        issue(OP_MTLO, 32'd9, 32'd0, 32'd5, 32'd9, 1'b0, 1, acc);
        issue(OP_DIV, 32'd50, 32'd0, 32'd5, 32'd9, 1'b1, 1, acc);
        issue(OP_MTLO, 32'h0BAD_F00D, 32'd0, 32'd5, 32'h0BAD_F00D, 1'b0, 1, acc);
        issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1, acc);
        issue(OP_MTLO, 32'h1234_5678, 32'd0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1, acc2);
        chk("b2b_gap", 64'(acc2 - acc), 64'd2);

        // MTHI held pending across the whole MULT; accepted on the edge ending done.
        issue(OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, LAT, acc);
        issue(OP_MTHI, 32'hA5A5_A5A5, 32'd0, 32'hA5A5_A5A5, 32'd12, 1'b0, 1, acc2);
        chk("hold_gap", 64'(acc2 - acc), 64'(LAT + 1));

        issue(OP_MULT, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, LAT, acc);
        while (cyc < acc + 10) @(negedge clock);
        #2 reset_n = 1'b0;
        sb.delete();
        st_q.delete();
        #1;
        chk("abort_hi", 64'(bus.hi), 64'd0);
        chk("abort_lo", 64'(bus.lo), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;
        repeat (LAT + 5) @(negedge clock);
        chk("post_rst_ready", 64'(bus.op_ready), 64'd1);
        chk("post_rst_lo", 64'(bus.lo), 64'd0);

        issue(OP_MULT, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0, LAT, acc);
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("start_q_drained", 64'(st_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
